hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_fwd_unit_if.sv | 37 +++
 rtl/hazard_fwd_cmp.sv | 35 +++
 rtl/hazard_fwd_unit.sv | 123 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: bypass selects, FSM states
// and the default register-address width.
package hazard_pkg;

    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle of the hazard/forwarding unit. The pipeline is the
// master (drives stage addresses and controls); the unit is the slave.
interface hazard_fwd_unit_if
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = DEF_REG_AW
);
    logic [NUM_SRC*REG_AW-1:0] rs_id;
    logic [NUM_SRC*REG_AW-1:0] rs_ex;
    logic [REG_AW-1:0]         rd_ex;
    logic [REG_AW-1:0]         rd_mem;
    logic [REG_AW-1:0]         rd_wb;
    logic                      regwr_ex;
    logic                      regwr_mem;
    logic                      regwr_wb;
    logic                      memrd_ex;
    logic                      mc_start;
    logic                      flush;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_if;
    logic                      stall_id;
    logic                      bubble_ex;
    logic                      busy;

    modport master (
        output rs_id, rs_ex, rd_ex, rd_mem, rd_wb,
        output regwr_ex, regwr_mem, regwr_wb, memrd_ex, mc_start, flush,
        input  fwd_sel, stall_if, stall_id, bubble_ex, busy
    );

    modport slave (
        input  rs_id, rs_ex, rd_ex, rd_mem, rd_wb,
        input  regwr_ex, regwr_mem, regwr_wb, memrd_ex, mc_start, flush,
        output fwd_sel, stall_if, stall_id, bubble_ex, busy
    );
endinterface

// File: rtl/hazard_fwd_cmp.sv
// One source-operand slot: bypass select against MEM/WB and a match of the
// ID-stage source against the EX destination for load-use detection.
module hazard_fwd_cmp
    import hazard_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] rs_ex_i,
    input  logic [REG_AW-1:0] rs_id_i,
    input  logic [REG_AW-1:0] rd_ex_i,
    input  logic [REG_AW-1:0] rd_mem_i,
    input  logic [REG_AW-1:0] rd_wb_i,
    input  logic              regwr_mem_i,
    input  logic              regwr_wb_i,
    output logic [1:0]        fwd_sel_o,
    output logic              id_match_o
);
    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a write to it never produces a forwardable value
    assign mem_hit = regwr_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_ex_i);
    assign wb_hit  = regwr_wb_i  && (rd_wb_i  != '0) && (rd_wb_i  == rs_ex_i);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (mem_hit) begin
            fwd_sel_o = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel_o = FWD_WB;
        end
    end

    assign id_match_o = (rd_ex_i != '0) && (rd_ex_i == rs_id_i);
endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for an in-order pipeline.
// Optional stall-cycle performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_fwd_unit_if.slave     bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles
`endif
);
    localparam int MC_W = $clog2(MC_LAT + 1);

    if ((NUM_SRC < 1) || (NUM_SRC > 4)) begin : g_bad_num_src
        $error("hazard_fwd_unit: NUM_SRC must be 1..4");
    end
    if (MC_LAT < 2) begin : g_bad_mc_lat
        $error("hazard_fwd_unit: MC_LAT must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_fwd_unit: CNT_W must be >= 1");
    end

    logic [NUM_SRC*2-1:0] fwd_sel_w;
    logic [NUM_SRC-1:0]   id_match_w;
    logic                 load_use_w;
    logic                 stall_w;
    logic                 bubble_w;

    hz_state_e            state_q;
    logic [MC_W-1:0]      cnt_q;
    logic                 busy_q;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
        hazard_fwd_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp (
            .rs_ex_i     (bus.rs_ex[gi*REG_AW +: REG_AW]),
            .rs_id_i     (bus.rs_id[gi*REG_AW +: REG_AW]),
            .rd_ex_i     (bus.rd_ex),
            .rd_mem_i    (bus.rd_mem),
            .rd_wb_i     (bus.rd_wb),
            .regwr_mem_i (bus.regwr_mem),
            .regwr_wb_i  (bus.regwr_wb),
            .fwd_sel_o   (fwd_sel_w[gi*2 +: 2]),
            .id_match_o  (id_match_w[gi])
        );
    end

    assign load_use_w = bus.memrd_ex && bus.regwr_ex && (|id_match_w);

    // mc_start outranks a coincident load-use: the multicycle stall covers it,
    // so no bubble is needed; flush overrides every stall request.
    assign stall_w  = !bus.flush &&
                      (((state_q == IDLE) && (load_use_w || bus.mc_start)) ||
                       (state_q == MC_BUSY));
    assign bubble_w = bus.flush ||
                      ((state_q == IDLE) && load_use_w && !bus.mc_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mc_start) begin
                        // The start cycle itself is the first of MC_LAT stalls
                        state_q <= MC_BUSY;
                        cnt_q   <= MC_W'(MC_LAT - 1);
                        busy_q  <= 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (cnt_q == MC_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - MC_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

    assign bus.fwd_sel   = fwd_sel_w;
    assign bus.stall_if  = stall_w;
    assign bus.stall_id  = stall_w;
    assign bus.bubble_ex = bubble_w;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit; the stall-counter test is built
// only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_fwd_unit;
    localparam int NUM_SRC = 2;
    localparam int REG_AW  = 5;
    localparam int MC_LAT  = 4;
    localparam int CNT_W   = 3;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_fwd_unit_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    hazard_fwd_unit #(
        .NUM_SRC (NUM_SRC),
        .REG_AW  (REG_AW),
        .MC_LAT  (MC_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_if, stall_id, bubble_ex, busy}
    function automatic logic [3:0] ctl();
        return {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.busy};
    endfunction

    task automatic drive_idle();
        bus.rs_id     = '0;
        bus.rs_ex     = '0;
        bus.rd_ex     = '0;
        bus.rd_mem    = '0;
        bus.rd_wb     = '0;
        bus.regwr_ex  = 1'b0;
        bus.regwr_mem = 1'b0;
        bus.regwr_wb  = 1'b0;
        bus.memrd_ex  = 1'b0;
        bus.mc_start  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [9:0] rs_id);
        bus.memrd_ex = 1'b1;
        bus.regwr_ex = 1'b1;
        bus.rd_ex    = rd;
        bus.rs_id    = rs_id;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle: got %b expected %b", ctl(), 4'b0000);
        end
        bus.mc_start = 1'b1;
        #1;
        n_vec++;
        if (ctl() !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_comb_follow: got %b expected %b", ctl(), 4'b1100);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (ctl() !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_holds_idle: got %b expected %b", ctl(), 4'b1100);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        $display("reset released: ctl=%b", ctl());
    endtask

    typedef struct packed {
        logic [9:0] rs_ex;
        logic [4:0] rd_mem;
        logic       wm;
        logic [4:0] rd_wb;
        logic       ww;
        logic [3:0] exp;
    } fv_t;

    task automatic test_forwarding();
        fv_t tbl[8];
        tbl[0] = '{{5'd9,  5'd5},  5'd5,  1'b1, 5'd5,  1'b1, 4'b0001};
        tbl[1] = '{{5'd9,  5'd5},  5'd5,  1'b0, 5'd5,  1'b1, 4'b0010};
        tbl[2] = '{{5'd0,  5'd0},  5'd0,  1'b1, 5'd0,  1'b1, 4'b0000};
        tbl[3] = '{{5'd4,  5'd3},  5'd4,  1'b1, 5'd3,  1'b1, 4'b0110};
        tbl[4] = '{{5'd3,  5'd3},  5'd3,  1'b1, 5'd3,  1'b0, 4'b0101};
        tbl[5] = '{{5'd31, 5'd30}, 5'd31, 1'b1, 5'd30, 1'b0, 4'b0100};
        tbl[6] = '{{5'd31, 5'd30}, 5'd31, 1'b0, 5'd30, 1'b1, 4'b0010};
        tbl[7] = '{{5'd0,  5'd2},  5'd0,  1'b1, 5'd2,  1'b1, 4'b0010};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_idle();
            bus.rs_ex     = tbl[i].rs_ex;
            bus.rd_mem    = tbl[i].rd_mem;
            bus.regwr_mem = tbl[i].wm;
            bus.rd_wb     = tbl[i].rd_wb;
            bus.regwr_wb  = tbl[i].ww;
            #1;
            n_vec++;
            if (bus.fwd_sel !== tbl[i].exp) begin
                n_err++;
                $display("FAIL fwd_sel[%0d]: got %b expected %b", i, bus.fwd_sel, tbl[i].exp);
            end else begin
                $display("fwd vec %0d: fwd_sel=%b", i, bus.fwd_sel);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_load_use();
        logic [3:0] exp [7];
        string      nm  [7];
        exp[0] = 4'b1110; nm[0] = "lu_slot1";
        exp[1] = 4'b0000; nm[1] = "lu_moved_on";
        exp[2] = 4'b0000; nm[2] = "lu_x0";
        exp[3] = 4'b0000; nm[3] = "lu_no_regwr";
        exp[4] = 4'b0000; nm[4] = "lu_no_memrd";
        exp[5] = 4'b0010; nm[5] = "lu_flush";
        exp[6] = 4'b1110; nm[6] = "lu_slot0";
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_idle();
            case (i)
                0: set_load_use(5'd7, {5'd7, 5'd3});
                2: set_load_use(5'd0, {5'd4, 5'd0});
                3: begin set_load_use(5'd7, {5'd7, 5'd3}); bus.regwr_ex = 1'b0; end
                4: begin set_load_use(5'd7, {5'd7, 5'd3}); bus.memrd_ex = 1'b0; end
                5: begin set_load_use(5'd7, {5'd7, 5'd3}); bus.flush = 1'b1; end
                6: set_load_use(5'd12, {5'd1, 5'd12});
                default: ;
            endcase
            #1;
            n_vec++;
            if (ctl() !== exp[i]) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", nm[i], ctl(), exp[i]);
            end else begin
                $display("load-use %s: ctl=%b", nm[i], ctl());
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_multicycle();
        logic [3:0] e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_idle();
            bus.mc_start = (i == 0);
            #1;
            e = {(i < 4), (i < 4), 1'b0, (i >= 1 && i < 4)};
            n_vec++;
            if (ctl() !== e) begin
                n_err++;
                $display("FAIL mc_cycle%0d: got %b expected %b", i, ctl(), e);
            end else begin
                $display("multicycle cycle %0d: ctl=%b", i, ctl());
            end
        end
    endtask

    task automatic test_flush_mid_busy();
        logic [3:0] exp [4];
        exp[0] = 4'b1100;
        exp[1] = 4'b1101;
        exp[2] = 4'b0011;
        exp[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_idle();
            bus.mc_start = (i == 0);
            bus.flush    = (i == 2);
            #1;
            n_vec++;
            if (ctl() !== exp[i]) begin
                n_err++;
                $display("FAIL flush_cycle%0d: got %b expected %b", i, ctl(), exp[i]);
            end else begin
                $display("flush cycle %0d: ctl=%b", i, ctl());
            end
        end
        // flush in IDLE also kills a starting multicycle op
        @(negedge clk);
        bus.mc_start = 1'b1;
        bus.flush    = 1'b1;
        #1;
        n_vec++;
        if (ctl() !== 4'b0010) begin
            n_err++;
            $display("FAIL flush_mc_start: got %b expected %b", ctl(), 4'b0010);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_mc_no_busy: got %b expected %b", ctl(), 4'b0000);
        end else begin
            $display("flush+mc_start: no busy afterwards, ctl=%b", ctl());
        end
    endtask

    task automatic test_busy_ignores();
        logic [3:0] exp [6];
        exp[0] = 4'b1100;
        exp[1] = 4'b1101;
        exp[2] = 4'b1101;
        exp[3] = 4'b1101;
        exp[4] = 4'b1110;
        exp[5] = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_idle();
            bus.mc_start = (i <= 1);
            if (i >= 1 && i <= 4) set_load_use(5'd7, {5'd3, 5'd7});
            #1;
            n_vec++;
            if (ctl() !== exp[i]) begin
                n_err++;
                $display("FAIL busy_ignore%0d: got %b expected %b", i, ctl(), exp[i]);
            end else begin
                $display("busy-ignore cycle %0d: ctl=%b", i, ctl());
            end
        end
    endtask

    task automatic test_mc_priority();
        logic [3:0] e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_idle();
            if (i == 0) begin
                set_load_use(5'd9, {5'd9, 5'd1});
                bus.mc_start = 1'b1;
            end
            #1;
            e = (i == 0) ? 4'b1100 : ((i < 4) ? 4'b1101 : 4'b0000);
            n_vec++;
            if (ctl() !== e) begin
                n_err++;
                $display("FAIL mc_priority%0d: got %b expected %b", i, ctl(), e);
            end else begin
                $display("mc-priority cycle %0d: ctl=%b", i, ctl());
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        drive_idle();
        bus.mc_start = 1'b1;
        @(negedge clk);
        bus.mc_start = 1'b0;
        #1;
        n_vec++;
        if (ctl() !== 4'b1101) begin
            n_err++;
            $display("FAIL rst_busy_pre: got %b expected %b", ctl(), 4'b1101);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_busy_async: got %b expected %b", ctl(), 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (ctl() !== 4'b0000) begin
                n_err++;
                $display("FAIL rst_busy_post%0d: got %b expected %b", i, ctl(), 4'b0000);
            end else begin
                $display("after reset cycle %0d: ctl=%b", i, ctl());
            end
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (stall_cycles !== 3'd0) begin
            n_err++;
            $display("FAIL perf_start: got %0d expected %0d", stall_cycles, 0);
        end
        set_load_use(5'd7, {5'd7, 5'd3});
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (stall_cycles !== 3'd5) begin
            n_err++;
            $display("FAIL perf_mid: got %0d expected %0d", stall_cycles, 5);
        end
        repeat (5) @(posedge clk);
        #1;
        drive_idle();
        n_vec++;
        if (stall_cycles !== 3'd7) begin
            n_err++;
            $display("FAIL perf_saturate: got %0d expected %0d", stall_cycles, 7);
        end else begin
            $display("perf counter after 10 stalls: %0d", stall_cycles);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (stall_cycles !== 3'd0) begin
            n_err++;
            $display("FAIL perf_reset: got %0d expected %0d", stall_cycles, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_flush_mid_busy();
        test_busy_ignores();
        test_mc_priority();
        test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
